// File: rtl/m_layer_output_acc_pkg.sv
// m_layer_output_acc_pkg: shared map-word width, accumulator default, phase encoding and 16-bit saturation
package m_layer_output_acc_pkg;
  localparam int PSUM_W = 16;
  localparam int ACC_W_DEF = 24;
  typedef enum logic [1:0] {LOAD, ACCUM, EMIT} acc_state_e;
  function automatic logic signed [PSUM_W-1:0] sat16(input logic signed [31:0] v);
    return v > 32'sd32767 ? 16'sh7fff : v < -32'sd32768 ? 16'sh8000 : v[PSUM_W-1:0];
  endfunction
endpackage

// File: rtl/m_layer_output_acc_ram.sv
// m_acc_ram: DEPTH x W accumulator store, async read / sync write; ports clk_in, i_we, i_waddr, i_wdata, i_raddr, o_rdata
module m_acc_ram #(
  parameter int DEPTH = 36,
  parameter int W = 24,
  parameter int AW = 6
) (
  input  logic          clk_in,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk_in)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/m_layer_output_acc.sv
// m_layer_output_acc: accumulates per-loop psums, adds bias, ReLU + sat16; ports clk_in, rst_n, psum_in/psum_valid, bias -> map_out/wr, frame_done, busy
module m_layer_output_acc
  import m_layer_output_acc_pkg::*;
#(
  parameter int NUM_OUT = 36,
  parameter int NUM_LOOP = 120,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic signed [PSUM_W-1:0] psum_in,
  input  logic                     psum_valid,
  input  logic signed [PSUM_W-1:0] bias,
  output logic signed [PSUM_W-1:0] map_out,
  output logic                     wr,
  output logic                     frame_done,
  output logic                     busy
);
  localparam int IW = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;
  localparam int LW = NUM_LOOP > 1 ? $clog2(NUM_LOOP) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_OUT - 1);
  localparam logic [LW-1:0] LOOP_LAST = LW'(NUM_LOOP - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [IW-1:0] r_idx;
  logic [LW-1:0] r_loop;
  logic signed [ACC_W-1:0] w_rd, w_base, w_acc_sat, w_wdata;
  logic signed [ACC_W:0] w_acc_sum;
  logic signed [ACC_W+1:0] w_sum;
  logic signed [PSUM_W-1:0] w_y;
  acc_state_e w_state;
  logic w_we;
  m_acc_ram #(.DEPTH(NUM_OUT), .W(ACC_W), .AW(IW)) u_ram (
    .clk_in (clk_in),
    .i_we   (w_we),
    .i_waddr(r_idx),
    .i_wdata(w_wdata),
    .i_raddr(r_idx),
    .o_rdata(w_rd)
  );
  // EMIT wins over LOAD so a single-loop frame emits with an empty accumulator
  always_comb begin
    w_state = r_loop == LOOP_LAST ? EMIT : r_loop == '0 ? LOAD : ACCUM;
    w_acc_sum = (ACC_W+1)'(w_rd) + (ACC_W+1)'(psum_in);
    w_acc_sat = w_acc_sum[ACC_W] != w_acc_sum[ACC_W-1] ? (w_acc_sum[ACC_W] ? ACC_MIN : ACC_MAX) : w_acc_sum[ACC_W-1:0];
    w_wdata = w_state == LOAD ? ACC_W'(psum_in) : w_acc_sat;
    w_base = NUM_LOOP == 1 ? '0 : w_rd;
    w_sum = (ACC_W+2)'(w_base) + (ACC_W+2)'(psum_in) + (ACC_W+2)'(bias);
    w_y = w_sum < 0 ? '0 : sat16(32'(w_sum));
    w_we = rst_n && psum_valid && w_state != EMIT;
  end
  always_ff @(posedge clk_in)
    if (!rst_n) begin
      r_idx <= '0;
      r_loop <= '0;
      map_out <= '0;
      wr <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wr <= psum_valid && w_state == EMIT;
      frame_done <= psum_valid && w_state == EMIT && r_idx == IDX_LAST;
      if (psum_valid) begin
        r_idx <= r_idx == IDX_LAST ? '0 : r_idx + 1'b1;
        if (r_idx == IDX_LAST) r_loop <= r_loop == LOOP_LAST ? '0 : r_loop + 1'b1;
        if (w_state == EMIT) map_out <= w_y;
      end
    end
  assign busy = r_loop != '0 || r_idx != '0;
endmodule

// File: tb/tb_m_layer_output_acc.sv
// tb_m_layer_output_acc: randomized frames vs per-element arithmetic model, ACC_W=24 and ACC_W=16 instances
module tb_m_layer_output_acc;
  localparam int N = 4;
  localparam int L = 3;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, psum_valid = 1'b0;
  logic signed [15:0] psum_in = '0, bias = '0;
  logic signed [15:0] map_a, map_b;
  logic wr_a, wr_b, fd_a, fd_b, busy_a, busy_b;
  int errors = 0, checks = 0, n_wr = 0, n_fd = 0;
  int p [L][N];
  int ya [N];
  int yb [N];
  logic t_emit = 1'b0, t_last = 1'b0, e_wr = 1'b0, e_fd = 1'b0, mon_en = 1'b0;
  int t_ya = 0, t_yb = 0, e_ya = 0, e_yb = 0;
  m_layer_output_acc #(.NUM_OUT(N), .NUM_LOOP(L), .ACC_W(24)) u_a (
    .clk_in(clk), .rst_n(rst_n), .psum_in(psum_in), .psum_valid(psum_valid), .bias(bias),
    .map_out(map_a), .wr(wr_a), .frame_done(fd_a), .busy(busy_a)
  );
  m_layer_output_acc #(.NUM_OUT(N), .NUM_LOOP(L), .ACC_W(16)) u_b (
    .clk_in(clk), .rst_n(rst_n), .psum_in(psum_in), .psum_valid(psum_valid), .bias(bias),
    .map_out(map_b), .wr(wr_b), .frame_done(fd_b), .busy(busy_b)
  );
  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int model(input int e, input int b, input int w);
    longint lo = -(longint'(1) << (w - 1));
    longint hi = (longint'(1) << (w - 1)) - 1;
    longint acc, s;
    acc = p[0][e];
    for (int l = 1; l < L - 1; l++) begin
      acc = acc + p[l][e];
      acc = acc > hi ? hi : acc < lo ? lo : acc;
    end
    s = acc + p[L-1][e] + b;
    return s < 0 ? 0 : s > 32767 ? 32767 : int'(s);
  endfunction
  always @(posedge clk) begin
    e_wr <= rst_n && psum_valid && t_emit;
    e_fd <= rst_n && psum_valid && t_last;
    e_ya <= t_ya;
    e_yb <= t_yb;
  end
  always @(negedge clk)
    if (mon_en) begin
      check("wr_a", wr_a, e_wr);
      check("wr_b", wr_b, e_wr);
      check("fd_a", fd_a, e_fd);
      check("fd_b", fd_b, e_fd);
      if (e_wr) begin
        check("map_a", map_a, e_ya);
        check("map_b", map_b, e_yb);
      end
      n_wr += int'(wr_a);
      n_fd += int'(fd_a);
    end
  task automatic drive(input logic v, input int ps, input int bs, input logic em, input int a, input int b, input logic last);
    @(posedge clk);
    #1;
    psum_valid = v;
    psum_in = 16'(ps);
    bias = 16'(bs);
    t_emit = em;
    t_ya = a;
    t_yb = b;
    t_last = last;
  endtask
  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
  endtask
  task automatic fill_rand();
    logic signed [15:0] r;
    for (int l = 0; l < L; l++)
      for (int e = 0; e < N; e++) begin
        r = 16'($urandom);
        p[l][e] = r;
      end
  endtask
  task automatic run_frame(input int gmax, input int bv);
    for (int e = 0; e < N; e++) begin
      ya[e] = model(e, bv, 24);
      yb[e] = model(e, bv, 16);
    end
    for (int l = 0; l < L; l++)
      for (int e = 0; e < N; e++) begin
        repeat ($urandom_range(gmax, 0)) drive(1'b0, int'($urandom), int'($urandom), 1'b0, 0, 0, 1'b0);
        drive(1'b1, p[l][e], l == L - 1 ? bv : int'($urandom), l == L - 1, ya[e], yb[e], l == L - 1 && e == N - 1);
      end
  endtask
  initial begin
    int w0, f0, bv;
    logic signed [15:0] rb;
    repeat (2) @(posedge clk);
    #1;
    check("rst_map", map_a, 0);
    check("rst_wr", wr_a, 0);
    check("rst_fd", fd_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int l = 0; l < L; l++)
      for (int e = 0; e < N; e++) p[l][e] = e + 1;
    run_frame(0, 10);
    idle();
    check("busy_end_a", busy_a, 0);
    check("busy_end_b", busy_b, 0);
    fill_rand();
    for (int l = 0; l < L; l++) begin
      p[l][0] = -100;
      p[l][1] = -3;
    end
    run_frame(0, 10);
    for (int l = 0; l < L; l++)
      for (int e = 0; e < N; e++) p[l][e] = 32767;
    run_frame(1, 10);
    fill_rand();
    p[0][0] = 32767;  p[1][0] = 32767;  p[2][0] = -32767;
    p[0][1] = -32768; p[1][1] = -32768; p[2][1] = 32767;
    run_frame(0, 10);
    repeat (3) begin
      fill_rand();
      rb = 16'($urandom);
      bv = rb;
      run_frame(5, bv);
    end
    idle();
    idle();
    w0 = n_wr;
    f0 = n_fd;
    fill_rand();
    run_frame(0, 10);
    fill_rand();
    run_frame(0, 10);
    idle();
    idle();
    check("b2b_wr", n_wr - w0, 8);
    check("b2b_fd", n_fd - f0, 2);
    fill_rand();
    for (int e = 0; e < N; e++) drive(1'b1, p[0][e], int'($urandom), 1'b0, 0, 0, 1'b0);
    for (int e = 0; e < 2; e++) drive(1'b1, p[1][e], int'($urandom), 1'b0, 0, 0, 1'b0);
    drive(1'b1, int'($urandom), int'($urandom), 1'b0, 0, 0, 1'b0);
    rst_n = 1'b0;
    check("busy_mid", busy_a, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    psum_valid = 1'b0;
    check("rstmid_wr", wr_a, 0);
    check("rstmid_map", map_a, 0);
    check("rstmid_busy_a", busy_a, 0);
    check("rstmid_busy_b", busy_b, 0);
    fill_rand();
    run_frame(2, 10);
    idle();
    check("busy_post", busy_a, 0);
    idle();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/m_layer_output_acc.md
# m_layer_output_acc

Output-side collector for a convolution layer: takes the partial-sum stream that a layer's kernel array produces once per input-channel loop, accumulates it across all loops, adds bias, applies ReLU and 16-bit saturation, and emits the finished feature map as a `map_out`/`wr` write stream. It is the producer that feeds the next layer's input buffer, whose write side is `map_in`/`wr`.

## Interface
Parameters:
- `NUM_OUT`, 36: output map elements per loop. Element index runs 0..NUM_OUT-1.
- `NUM_LOOP`, 120: loops (partial-sum passes) per frame. Must be ≥1.
- `ACC_W`, 24: accumulator width, signed.

Ports:
- `clk_in`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `psum_in`  in  16  signed partial sum for the current element.
- `psum_valid`  in  1  `psum_in` is valid this cycle.
- `bias`  in  16  signed layer bias. Sampled only on last-loop beats.
- `map_out`  out  16  signed final map value.
- `wr`  out  1  `map_out` valid. This is the write strobe for the next layer's buffer.
- `frame_done`  out  1  one-cycle pulse coincident with the last `wr` of a frame.
- `busy`  out  1  high while a frame is partially accumulated.

## Operation
- Counters:
  - `idx` (element, 0..NUM_OUT-1) advances on each `psum_valid` and wraps to 0.
  - On wrap, `loop_cnt` (0..NUM_LOOP-1) advances. It wraps to 0 after NUM_LOOP-1.
- States are LOAD, ACCUM and EMIT, decoded from `loop_cnt`:
  - LOAD: `loop_cnt`==0. `acc[idx] <= sext(psum_in)`. Old contents are ignored, so no clear pass is needed.
  - ACCUM: 0<`loop_cnt`<NUM_LOOP-1. `acc[idx] <= sat_ACC(acc[idx] + psum_in)`.
  - EMIT: `loop_cnt`==NUM_LOOP-1.
    - Compute `s = acc[idx] + psum_in + bias` in ACC_W+2 bits.
    - `y = (s<0) ? 0 : (s>32767 ? 32767 : s)`.
    - Register `y` to `map_out` and assert `wr`.
    - `acc` is not written.
  - When NUM_LOOP==1, LOAD and EMIT coincide. Use EMIT with `acc` treated as 0.
- `sat_ACC` clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- `psum_valid` may have arbitrary gaps. Nothing advances without it.
- `busy` = (`loop_cnt`!=0) || (`idx`!=0).
- Psum input data is never dropped. There is no backpressure: the downstream buffer always accepts `wr`.

## Timing
- Reset values: `map_out`=0, `wr`=0, `frame_done`=0, `busy`=0, `idx`=0, `loop_cnt`=0. `acc` contents are don't-care.
- Latency: `wr`/`map_out` are registered 1 cycle after the EMIT-loop `psum_valid` beat.
- The `wr` pattern mirrors the `psum_valid` pattern of the final loop, exactly NUM_OUT strobes per frame.
- `frame_done` is asserted in the same cycle as the `wr` for element NUM_OUT-1.
- Back-to-back frames: the beat after the last EMIT beat is LOAD of element 0 of the next frame. There is no idle cycle.
- Read-modify-write is single-cycle (asynchronous accumulator read, synchronous write). Each beat touches a distinct `idx`, so there is no hazard.
- `rst_n` low mid-frame:
  - Counters and outputs return to reset values on the next edge.
  - A `psum_valid` in the reset cycle is ignored.
  - The next post-reset beat is LOAD `idx`=0.

## Structure
- Shared package: a `PSUM_W`=16 constant, a `sat16` function, and an `ACC_W` default. The next-layer input buffer uses the same 16-bit map word.
- Sub-module `m_acc_ram`: NUM_OUT×ACC_W storage with asynchronous read and synchronous write (distributed RAM), plus read and write address ports.
- The top level holds the counters, state decode, adder/saturation datapath and output registers.

## Test plan
Bench parameters: NUM_OUT=4, NUM_LOOP=3, bias=10.
- **Accumulate:** psums 1,2,3,4 on all three loops, continuous valid → `wr` ×4 with `map_out` 13,16,19,22; `frame_done` with 22; `busy` falls after the last beat.
- **ReLU:** psums -100 every loop for element 0 → `map_out`=0. Element 1 with -3 per loop and bias 10 → s=1, `map_out`=1.
- **Saturation:** psum 32767 on every loop → `map_out`=32767, no wrap. Set ACC_W=16, feed 32767 twice, then 0 → acc clamps at 32767, output 32767.
- **Gapped valid:** random 0–5 idle cycles between beats → identical `map_out` sequence; each `wr` exactly 1 cycle after its EMIT beat.
- **Back-to-back frames:** two frames with different data → second frame's results are independent of the first (LOAD overwrites); 8 `wr` total; 2 `frame_done` pulses.
- **Reset mid-frame:** assert `rst_n`=0 for 1 cycle during loop 1, `idx` 2 → `wr`=0 and `busy`=0 after the edge; a following full frame produces the correct results.
